// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the writeback queue.
package writeback_queue_pkg;

    localparam int unsigned REG_ADDR_W        = 5;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned WBQ_DEPTH_DEFAULT = 4;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wbq_entry_t;

    // Number of producers that can enqueue in one cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ONE  = 2'd1,
        SRC_TWO  = 2'd2
    } wbq_push_cnt_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned wbq_count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/writeback_queue_fifo.sv
// wbq_fifo: circular storage for pending writes with head/tail/count.
// Accepts up to two entries per cycle (slot a older than slot b) and one pop.
// Macro WBQ_FORWARD_EN: exposes the entries in age order for forwarding.
module wbq_fifo
    import writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_push_a,
    input  wbq_entry_t                         i_ent_a,
    input  logic                               i_push_b,
    input  wbq_entry_t                         i_ent_b,
    input  logic                               i_pop,
    output wbq_entry_t                         o_head_ent,
    output logic [wbq_count_w(DEPTH)-1:0]      o_count,
    output logic                               o_full,
    output logic                               o_empty
`ifdef WBQ_FORWARD_EN
    ,
    output wbq_entry_t                         o_entries [DEPTH]
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = wbq_count_w(DEPTH);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    wbq_entry_t    r_mem [DEPTH];

    logic          w_pop;
    logic [PW-1:0] w_tail_b;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;
    wbq_push_cnt_e w_push_kind;

    assign w_pop    = i_pop && (r_count != '0);
    // Slot b lands after slot a only when slot a is actually written.
    assign w_tail_b = r_tail + PW'(i_push_a);

    // Classify the number of entries written this cycle.
    always_comb begin
        w_push_kind = SRC_NONE;
        if (i_push_a && i_push_b) begin
            w_push_kind = SRC_TWO;
        end else if (i_push_a || i_push_b) begin
            w_push_kind = SRC_ONE;
        end
    end

    assign w_push_n = CW'(w_push_kind);
    assign w_pop_n  = CW'(w_pop);

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (i_push_a) begin
            r_mem[r_tail] <= i_ent_a;
        end
        if (i_push_b) begin
            r_mem[w_tail_b] <= i_ent_b;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    assign o_head_ent = r_mem[r_head];
    assign o_count    = r_count;
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);

`ifdef WBQ_FORWARD_EN
    // Rotate storage so index 0 is the oldest entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_entries[i] = r_mem[r_head + PW'(i)];
        end
    end
`endif

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: merges ALU and load results into one registered
// register-file write port through a small pending-write FIFO.
// Macro WBQ_FORWARD_EN: enables the fwd_reg lookup; otherwise fwd_* are 0.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    output logic                  RegWriteSig,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    input  logic [REG_ADDR_W-1:0] fwd_reg,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data
);

    localparam int unsigned CW = wbq_count_w(DEPTH);

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    logic          w_full;
    logic          w_empty;
    logic          w_mem_acc;
    logic          w_alu_acc;
    logic          w_push_mem;
    logic          w_push_alu;
    logic          w_pop;
    wbq_entry_t    w_ent_mem;
    wbq_entry_t    w_ent_alu;
    wbq_entry_t    w_head_ent;

`ifdef WBQ_FORWARD_EN
    wbq_entry_t    w_entries [DEPTH];
`endif

    // Free space comes from the registered count; a same-cycle pop does not add room.
    assign w_free = CW'(DEPTH) - w_count;

    // Readies: load path needs one slot, ALU needs two when a load competes.
    always_comb begin
        mem_ready = 1'b0;
        alu_ready = 1'b0;
        if (!reset) begin
            mem_ready = !w_full;
            alu_ready = mem_valid ? (w_free >= CW'(2)) : !w_full;
        end
    end

    assign w_mem_acc  = mem_valid && mem_ready;
    assign w_alu_acc  = alu_valid && alu_ready;
    // Writes to r0 complete the handshake but are dropped.
    assign w_push_mem = w_mem_acc && (mem_reg != '0);
    assign w_push_alu = w_alu_acc && (alu_reg != '0);
    assign w_pop      = !w_empty;

    assign w_ent_mem  = '{dst: mem_reg, data: mem_data};
    assign w_ent_alu  = '{dst: alu_reg, data: alu_data};

    // Load result takes slot a so it is older than a same-cycle ALU result.
    wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_push_a   (w_push_mem),
        .i_ent_a    (w_ent_mem),
        .i_push_b   (w_push_alu),
        .i_ent_b    (w_ent_alu),
        .i_pop      (w_pop),
        .o_head_ent (w_head_ent),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
`ifdef WBQ_FORWARD_EN
        ,
        .o_entries  (w_entries)
`endif
    );

    // Output stage: issue the head entry every cycle the queue is non-empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteSig <= 1'b0;
            writeReg    <= '0;
            writeData   <= '0;
        end else if (!w_empty) begin
            RegWriteSig <= 1'b1;
            writeReg    <= w_head_ent.dst;
            writeData   <= w_head_ent.data;
        end else begin
            RegWriteSig <= 1'b0;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Forwarding lookup: output stage is the oldest candidate, then FIFO
    // entries oldest-to-youngest overwrite it, so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_reg != '0) begin
            if (RegWriteSig && (writeReg == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = writeData;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < w_count) && (w_entries[i].dst == fwd_reg)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = w_entries[i].data;
                end
            end
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^fwd_reg;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_reg, mem_reg, fwd_reg;
    logic [31:0] alu_data, mem_data;

    // index 0: DEPTH=4 instance, index 1: DEPTH=2 instance
    logic        mrdy_o [2];
    logic        ardy_o [2];
    logic        rw_o   [2];
    logic        fhit_o [2];
    logic [4:0]  wreg_o [2];
    logic [31:0] wdata_o[2];
    logic [31:0] fdata_o[2];

    initial forever #5 clk = ~clk;

    writeback_queue #(.DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(ardy_o[0]),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mrdy_o[0]),
        .RegWriteSig(rw_o[0]), .writeReg(wreg_o[0]), .writeData(wdata_o[0]),
        .fwd_reg(fwd_reg), .fwd_hit(fhit_o[0]), .fwd_data(fdata_o[0])
    );

    writeback_queue #(.DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(ardy_o[1]),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mrdy_o[1]),
        .RegWriteSig(rw_o[1]), .writeReg(wreg_o[1]), .writeData(wdata_o[1]),
        .fwd_reg(fwd_reg), .fwd_hit(fhit_o[1]), .fwd_data(fdata_o[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: ring of pending {reg,data} per instance, plus output stage.
    logic [36:0] mbuf [2][256];
    int          mh [2];
    int          mt [2];
    logic        erw [2];
    logic [4:0]  ewr [2];
    logic [31:0] ewd [2];
    logic        s_mrdy [2];
    logic        s_ardy [2];
    logic        s_fhit [2];
    logic [31:0] s_fdata[2];

    function automatic int mdepth(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mt[k] = 0; erw[k] = 1'b0; ewr[k] = '0; ewd[k] = '0;
        end
    endtask

    task automatic step(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic [4:0] fr);
        int   cnt [2];
        logic em [2];
        logic ea [2];
        logic eh;
        logic [31:0] ed;
        logic found;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        fwd_reg   = fr;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cnt[k] = mt[k] - mh[k];
            em[k]  = (mdepth(k) - cnt[k]) >= 1;
            ea[k]  = mv ? ((mdepth(k) - cnt[k]) >= 2) : ((mdepth(k) - cnt[k]) >= 1);
            s_mrdy[k] = mrdy_o[k]; s_ardy[k] = ardy_o[k];
            s_fhit[k] = fhit_o[k]; s_fdata[k] = fdata_o[k];
            check($sformatf("d%0d_mem_ready", k), 32'(mrdy_o[k]), 32'(em[k]));
            check($sformatf("d%0d_alu_ready", k), 32'(ardy_o[k]), 32'(ea[k]));
            eh = 1'b0; ed = '0; found = 1'b0;
            if (FWD && fr != 5'd0) begin
                for (int i = mt[k] - 1; i >= mh[k]; i--) begin
                    if (!found && mbuf[k][i % 256][36:32] == fr) begin
                        found = 1'b1; eh = 1'b1; ed = mbuf[k][i % 256][31:0];
                    end
                end
                if (!found && erw[k] && ewr[k] == fr) begin
                    eh = 1'b1; ed = ewd[k];
                end
            end
            check($sformatf("d%0d_fwd_hit", k), 32'(fhit_o[k]), 32'(eh));
            check($sformatf("d%0d_fwd_data", k), fdata_o[k], ed);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cnt[k] > 0) begin
                erw[k] = 1'b1;
                ewr[k] = mbuf[k][mh[k] % 256][36:32];
                ewd[k] = mbuf[k][mh[k] % 256][31:0];
                mh[k]++;
            end else begin
                erw[k] = 1'b0;
            end
            if (mv && em[k] && mr != 5'd0) begin mbuf[k][mt[k] % 256] = {mr, md}; mt[k]++; end
            if (av && ea[k] && ar != 5'd0) begin mbuf[k][mt[k] % 256] = {ar, ad}; mt[k]++; end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_RegWriteSig", k), 32'(rw_o[k]), 32'(erw[k]));
            check($sformatf("d%0d_writeReg", k), 32'(wreg_o[k]), 32'(ewr[k]));
            check($sformatf("d%0d_writeData", k), wdata_o[k], ewd[k]);
        end
    endtask

    typedef struct {
        logic mv; logic [4:0] mr; logic [31:0] md;
        logic av; logic [4:0] ar; logic [31:0] ad;
        logic [4:0] fr;
        logic emr; logic ear; logic efh; logic [31:0] efd;
        logic erw; logic [4:0] ewr; logic [31:0] ewd;
    } vec_t;

    function automatic vec_t mk(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic [4:0] fr, input logic emr, input logic ear,
                                input logic efh, input logic [31:0] efd,
                                input logic erw_i, input logic [4:0] ewr_i, input logic [31:0] ewd_i);
        vec_t v;
        v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad; v.fr = fr;
        v.emr = emr; v.ear = ear; v.efh = efh & FWD; v.efd = FWD ? efd : 32'd0;
        v.erw = erw_i; v.ewr = ewr_i; v.ewd = ewd_i;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // DEPTH=4 directed sequence; hand-derived expectations
        tbl[0]  = mk(0, 0, 0,       1, 20, 50,       0,  1, 1, 0, 0,     0, 0, 0);
        tbl[1]  = mk(0, 0, 0,       0, 0, 0,         20, 1, 1, 1, 50,    1, 20, 50);
        tbl[2]  = mk(0, 0, 0,       0, 0, 0,         20, 1, 1, 1, 50,    0, 20, 50);
        tbl[3]  = mk(1, 1, 'h11,    1, 2, 'h22,      20, 1, 1, 0, 0,     0, 20, 50);
        tbl[4]  = mk(1, 5, 'h55,    1, 6, 'h66,      0,  1, 1, 0, 0,     1, 1, 'h11);
        tbl[5]  = mk(1, 3, 'hAA,    1, 4, 'hBB,      0,  1, 0, 0, 0,     1, 2, 'h22);
        tbl[6]  = mk(0, 0, 0,       1, 4, 'hBB,      0,  1, 1, 0, 0,     1, 5, 'h55);
        tbl[7]  = mk(0, 0, 0,       0, 0, 0,         3,  1, 1, 1, 'hAA,  1, 6, 'h66);
        tbl[8]  = mk(0, 0, 0,       0, 0, 0,         6,  1, 1, 1, 'h66,  1, 3, 'hAA);
        tbl[9]  = mk(0, 0, 0,       1, 0, 'h1234,    0,  1, 1, 0, 0,     1, 4, 'hBB);
        tbl[10] = mk(0, 0, 0,       0, 0, 0,         0,  1, 1, 0, 0,     0, 4, 'hBB);
        tbl[11] = mk(1, 7, 'h11,    1, 7, 'h22,      7,  1, 1, 0, 0,     0, 4, 'hBB);
        tbl[12] = mk(0, 0, 0,       0, 0, 0,         7,  1, 1, 1, 'h22,  1, 7, 'h11);
        tbl[13] = mk(0, 0, 0,       0, 0, 0,         7,  1, 1, 1, 'h22,  1, 7, 'h22);
        tbl[14] = mk(0, 0, 0,       0, 0, 0,         7,  1, 1, 1, 'h22,  0, 7, 'h22);
        tbl[15] = mk(1, 0, 'h99,    0, 0, 0,         7,  1, 1, 0, 0,     0, 7, 'h22);

        reset = 1'b1;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        alu_valid = 0; alu_reg = 0; alu_data = 0; fwd_reg = 0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_d%0d_rw", k), 32'(rw_o[k]), 32'd0);
            check($sformatf("rst_d%0d_wreg", k), 32'(wreg_o[k]), 32'd0);
            check($sformatf("rst_d%0d_wdata", k), wdata_o[k], 32'd0);
            check($sformatf("rst_d%0d_mrdy", k), 32'(mrdy_o[k]), 32'd0);
            check($sformatf("rst_d%0d_ardy", k), 32'(ardy_o[k]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rel_mrdy", 32'(mrdy_o[0]), 32'd1);
        check("rel_ardy", 32'(ardy_o[0]), 32'd1);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].fr);
            check($sformatf("t%0d_mrdy", i), 32'(s_mrdy[0]), 32'(tbl[i].emr));
            check($sformatf("t%0d_ardy", i), 32'(s_ardy[0]), 32'(tbl[i].ear));
            check($sformatf("t%0d_fhit", i), 32'(s_fhit[0]), 32'(tbl[i].efh));
            check($sformatf("t%0d_fdata", i), s_fdata[0], tbl[i].efd);
            check($sformatf("t%0d_rw", i), 32'(rw_o[0]), 32'(tbl[i].erw));
            check($sformatf("t%0d_wreg", i), 32'(wreg_o[0]), 32'(tbl[i].ewr));
            check($sformatf("t%0d_wdata", i), wdata_o[0], tbl[i].ewd);
        end

        // Full queue on the DEPTH=2 instance: readies drop, pop proceeds, readies return
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 'h101, 1, 2, 'h102, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("full_mrdy", 32'(s_mrdy[1]), 32'd0);
        check("full_ardy", 32'(s_ardy[1]), 32'd0);
        check("full_pop1_rw", 32'(rw_o[1]), 32'd1);
        check("full_pop1_reg", 32'(wreg_o[1]), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("after_full_mrdy", 32'(s_mrdy[1]), 32'd1);
        check("after_full_ardy", 32'(s_ardy[1]), 32'd1);
        check("full_pop2_reg", 32'(wreg_o[1]), 32'd2);
        check("full_pop2_data", wdata_o[1], 32'h102);

        // Reset with three entries pending in the DEPTH=4 instance
        step(1, 1, 'h1, 1, 2, 'h2, 0);
        step(1, 3, 'h3, 1, 4, 'h4, 0);
        mem_valid = 0; alu_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mid_rst_d%0d_rw", k), 32'(rw_o[k]), 32'd0);
            check($sformatf("mid_rst_d%0d_wreg", k), 32'(wreg_o[k]), 32'd0);
            check($sformatf("mid_rst_d%0d_mrdy", k), 32'(mrdy_o[k]), 32'd0);
            check($sformatf("mid_rst_d%0d_ardy", k), 32'(ardy_o[k]), 32'd0);
        end
        @(posedge clk); #1;
        check("in_rst_rw", 32'(rw_o[0]), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_mrdy", 32'(mrdy_o[0]), 32'd1);
        check("post_rst_ardy", 32'(ardy_o[0]), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_no_write", 32'(rw_o[0]), 32'd0);
        step(0, 0, 0, 1, 20, 50, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_push_rw", 32'(rw_o[0]), 32'd1);
        check("post_rst_push_reg", 32'(wreg_o[0]), 32'd20);
        check("post_rst_push_data", wdata_o[0], 32'd50);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_push_done", 32'(rw_o[0]), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
